// File: rtl/llc_cmd_dispatcher_pkg.sv
// Shared LLC trace definitions: field widths, command codes, dispatcher FSM states
// and the legal-command filter used by the dispatcher front end.
package llc_cmd_dispatcher_pkg;

    localparam int CMDSIZE   = 4;
    localparam int ADDR_BITS = 32;

    typedef enum logic [CMDSIZE-1:0] {
        CMD_READ_L1D    = 4'd0,
        CMD_WRITE_L1D   = 4'd1,
        CMD_READ_L1I    = 4'd2,
        CMD_SNOOP_INV   = 4'd3,
        CMD_SNOOP_READ  = 4'd4,
        CMD_SNOOP_WRITE = 4'd5,
        CMD_SNOOP_RWIM  = 4'd6,
        CMD_CLEAR       = 4'd8,
        CMD_PRINT       = 4'd9
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        FIRE,
        GAP
    } disp_state_t;

    // Codes 7 and 10-15 have no meaning to the LLC model.
    function automatic logic is_legal_cmd(input logic [CMDSIZE-1:0] cmd);
        logic ok;
        ok = 1'b0;
        case (cmd)
            CMD_READ_L1D, CMD_WRITE_L1D, CMD_READ_L1I, CMD_SNOOP_INV,
            CMD_SNOOP_READ, CMD_SNOOP_WRITE, CMD_SNOOP_RWIM,
            CMD_CLEAR, CMD_PRINT: ok = 1'b1;
            default:              ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/llc_cmd_dispatcher_fifo.sv
// llc_cmd_fifo: synchronous record buffer with wrap-bit pointers; a full FIFO refuses
// pushes even when a pop happens in the same cycle.
module llc_cmd_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/llc_cmd_dispatcher.sv
// Trace-record dispatcher for the LLC model: filters, buffers and replays records with a
// one-cycle llc_eof strobe. Define LLC_DISPATCH_TRACE_EN for simulation trace printing.
module llc_cmd_dispatcher
    import llc_cmd_dispatcher_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CMDSIZE-1:0]   in_cmd,
    input  logic [ADDR_BITS-1:0] in_addr,
    output logic [CMDSIZE-1:0]   llc_cmd,
    output logic [ADDR_BITS-1:0] llc_addr,
    output logic                 llc_eof,
    output logic                 idle,
    output logic [31:0]          issued_cnt,
    output logic [31:0]          dropped_cnt
);

    localparam int REC_W = CMDSIZE + ADDR_BITS;
    localparam int GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    disp_state_t          state;
    disp_state_t          state_nxt;
    logic [GW-1:0]        gap_cnt;
    logic                 ready_q;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [REC_W-1:0]     head;
    logic                 accept;
    logic                 push;
    logic                 drop;
    logic                 pop;

    assign in_ready = ready_q && !fifo_full;
    assign accept   = in_valid && in_ready;
    assign push     = accept && is_legal_cmd(in_cmd);
    assign drop     = accept && !is_legal_cmd(in_cmd);
    assign pop      = (state == IDLE) && !fifo_empty;
    assign idle     = fifo_empty && (state == IDLE);

    llc_cmd_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .wdata   ({in_cmd, in_addr}),
        .rdata   (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!fifo_empty) state_nxt = SETUP;
            SETUP:   state_nxt = FIRE;
            FIRE:    state_nxt = GAP;
            GAP:     if (gap_cnt == GW'(GAP_CYCLES - 1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // llc_eof is registered from the next state so it rises on the SETUP->FIRE edge
    // and any reset edge clears it with the state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            gap_cnt     <= '0;
            ready_q     <= 1'b0;
            llc_cmd     <= '0;
            llc_addr    <= '0;
            llc_eof     <= 1'b0;
            issued_cnt  <= '0;
            dropped_cnt <= '0;
        end else begin
            state   <= state_nxt;
            ready_q <= 1'b1;
            llc_eof <= (state_nxt == FIRE);
            gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
            if (pop) {llc_cmd, llc_addr} <= head;
            if (state == SETUP && issued_cnt != '1) issued_cnt <= issued_cnt + 1'b1;
            if (drop && dropped_cnt != '1)          dropped_cnt <= dropped_cnt + 1'b1;
        end
    end

`ifdef LLC_DISPATCH_TRACE_EN
    always_ff @(posedge clk) begin
        if (reset_n && state == FIRE)
            $display("[llc_dispatch] issue #%h cmd=%h addr=%h", issued_cnt, llc_cmd, llc_addr);
        if (drop)
            $display("[llc_dispatch] drop illegal cmd=%h addr=%h", in_cmd, in_addr);
    end
`else
    // Trace printing disabled; cycle behaviour is identical.
`endif

endmodule

// File: tb/tb_llc_cmd_dispatcher.sv
// Directed self-checking bench for llc_cmd_dispatcher (FIFO_DEPTH=8, GAP_CYCLES=1).
module tb_llc_cmd_dispatcher;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_cmd;
    logic [31:0] in_addr;
    logic [3:0]  llc_cmd;
    logic [31:0] llc_addr;
    logic        llc_eof;
    logic        idle;
    logic [31:0] issued_cnt;
    logic [31:0] dropped_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int exp_issued  = 0;
    int exp_dropped = 0;

    logic [3:0] legal_list [10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd0};

    typedef struct {
        int          cyc;
        logic [3:0]  cmd;
        logic [31:0] addr;
    } pulse_t;

    pulse_t pq[$];
    int     long_err = 0;
    logic   prev_eof = 1'b0;

    llc_cmd_dispatcher #(
        .FIFO_DEPTH (8),
        .GAP_CYCLES (1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_cmd      (in_cmd),
        .in_addr     (in_addr),
        .llc_cmd     (llc_cmd),
        .llc_addr    (llc_addr),
        .llc_eof     (llc_eof),
        .idle        (idle),
        .issued_cnt  (issued_cnt),
        .dropped_cnt (dropped_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every strobe cycle; two consecutive high samples mean a stretched strobe.
    always @(negedge clk) begin
        pulse_t p;
        if (llc_eof === 1'b1) begin
            p.cyc  = cyc;
            p.cmd  = llc_cmd;
            p.addr = llc_addr;
            pq.push_back(p);
            if (prev_eof) long_err++;
        end
        prev_eof = (llc_eof === 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int n, input int budget);
        int k = 0;
        while (!(pq.size() >= n && idle === 1'b1) && k < budget) begin
            tick();
            k++;
        end
        n_tests++;
        if (k >= budget) begin
            n_fail++;
            $display("FAIL drain: got %0d pulses, expected %0d", pq.size(), n);
        end
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_cmd   = '0;
        in_addr  = '0;
        repeat (3) tick();
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
        n_tests++; if (llc_eof !== 1'b0) begin n_fail++; $display("FAIL rst_eof: got %b expected 0", llc_eof); end
        n_tests++; if (llc_cmd !== 4'h0) begin n_fail++; $display("FAIL rst_cmd: got %h expected 0", llc_cmd); end
        n_tests++; if (llc_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h expected 0", llc_addr); end
        n_tests++; if (issued_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_issued: got %0d expected 0", issued_cnt); end
        n_tests++; if (dropped_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_dropped: got %0d expected 0", dropped_cnt); end
        reset_n = 1'b1;
        tick();
        tick();
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got %b expected 1", in_ready); end
        n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL post_rst_idle: got %b expected 1", idle); end
        pq.delete();
    endtask

    task automatic test_single();
        pq.delete();
        in_valid = 1'b1;
        in_cmd   = 4'd0;
        in_addr  = 32'h0000_1040;
        tick();                         // enqueue edge
        in_valid = 1'b0;
        tick();                         // pop edge, now SETUP
        n_tests++; if (llc_cmd !== 4'd0) begin n_fail++; $display("FAIL single_cmd: got %h expected 0", llc_cmd); end
        n_tests++; if (llc_addr !== 32'h1040) begin n_fail++; $display("FAIL single_addr: got %h expected 1040", llc_addr); end
        n_tests++; if (llc_eof !== 1'b0) begin n_fail++; $display("FAIL single_setup_eof: got %b expected 0", llc_eof); end
        tick();                         // FIRE
        n_tests++; if (llc_eof !== 1'b1) begin n_fail++; $display("FAIL single_fire_eof: got %b expected 1", llc_eof); end
        tick();
        exp_issued++;
        n_tests++; if (llc_eof !== 1'b0) begin n_fail++; $display("FAIL single_gap_eof: got %b expected 0", llc_eof); end
        n_tests++; if (issued_cnt !== 32'(exp_issued)) begin n_fail++; $display("FAIL single_issued: got %0d expected %0d", issued_cnt, exp_issued); end
        wait_drain(1, 20);
        n_tests++; if (pq.size() != 1) begin n_fail++; $display("FAIL single_pulses: got %0d expected 1", pq.size()); end
    endtask

    task automatic test_burst();
        int acc = 0;
        int low_cnt = 0;
        int first_low = -1;
        int guard = 0;
        logic r;
        pq.delete();
        while (acc < 12 && guard < 200) begin
            in_valid = 1'b1;
            in_cmd   = legal_list[acc % 10];
            in_addr  = 32'h100 + 32'(acc);
            r = in_ready;
            tick();
            if (r) acc++;
            else begin
                low_cnt++;
                if (first_low < 0) first_low = acc;
            end
            guard++;
        end
        in_valid = 1'b0;
        // Drain overlaps the burst: occupancy reaches 8 on the 11th accept and
        // the next pop frees a slot three cycles later.
        n_tests++; if (first_low != 11) begin n_fail++; $display("FAIL burst_full_at: got %0d expected 11", first_low); end
        n_tests++; if (low_cnt != 3) begin n_fail++; $display("FAIL burst_ready_low: got %0d expected 3", low_cnt); end
        wait_drain(12, 200);
        exp_issued += 12;
        for (int i = 0; i < pq.size() && i < 12; i++) begin
            n_tests++;
            if (pq[i].cmd !== legal_list[i % 10] || pq[i].addr !== 32'h100 + 32'(i)) begin
                n_fail++;
                $display("FAIL burst_rec%0d: got %h/%h expected %h/%h", i, pq[i].cmd, pq[i].addr, legal_list[i % 10], 32'h100 + 32'(i));
            end
            if (i > 0) begin
                n_tests++;
                if (pq[i].cyc - pq[i-1].cyc != 4) begin
                    n_fail++;
                    $display("FAIL burst_spacing%0d: got %0d expected 4", i, pq[i].cyc - pq[i-1].cyc);
                end
            end
        end
        n_tests++; if (issued_cnt !== 32'(exp_issued)) begin n_fail++; $display("FAIL burst_issued: got %0d expected %0d", issued_cnt, exp_issued); end
        n_tests++; if (long_err != 0) begin n_fail++; $display("FAIL burst_strobe_width: got %0d stretched expected 0", long_err); end
    endtask

    task automatic test_filter();
        pq.delete();
        in_valid = 1'b1;
        in_addr  = 32'h2000;
        in_cmd   = 4'd7;  tick();
        in_cmd   = 4'd12; tick();
        in_cmd   = 4'd1;  tick();
        in_valid = 1'b0;
        exp_dropped += 2;
        exp_issued  += 1;
        wait_drain(1, 30);
        repeat (8) tick();
        n_tests++; if (dropped_cnt !== 32'(exp_dropped)) begin n_fail++; $display("FAIL filter_dropped: got %0d expected %0d", dropped_cnt, exp_dropped); end
        n_tests++; if (pq.size() != 1) begin n_fail++; $display("FAIL filter_pulses: got %0d expected 1", pq.size()); end
        if (pq.size() > 0) begin
            n_tests++; if (pq[0].cmd !== 4'd1) begin n_fail++; $display("FAIL filter_cmd: got %h expected 1", pq[0].cmd); end
            n_tests++; if (pq[0].addr !== 32'h2000) begin n_fail++; $display("FAIL filter_addr: got %h expected 2000", pq[0].addr); end
        end
        n_tests++; if (issued_cnt !== 32'(exp_issued)) begin n_fail++; $display("FAIL filter_issued: got %0d expected %0d", issued_cnt, exp_issued); end
    endtask

    task automatic test_simul_push_pop();
        int j = 0;
        bit v;
        pq.delete();
        // Four back-to-back pushes leave occupancy 3; later pushes land on pop edges.
        for (int n = 1; n <= 28; n++) begin
            v = (n <= 4) || (n >= 6 && n <= 26 && ((n - 6) % 4) == 0);
            in_valid = v;
            in_cmd   = legal_list[j % 10];
            in_addr  = 32'h3000 + 32'(j);
            tick();
            if (v) j++;
        end
        in_valid = 1'b0;
        wait_drain(j, 100);
        exp_issued += j;
        n_tests++; if (pq.size() != 10) begin n_fail++; $display("FAIL simul_count: got %0d expected 10", pq.size()); end
        for (int i = 0; i < pq.size() && i < 10; i++) begin
            n_tests++;
            if (pq[i].cmd !== legal_list[i % 10] || pq[i].addr !== 32'h3000 + 32'(i)) begin
                n_fail++;
                $display("FAIL simul_rec%0d: got %h/%h expected %h/%h", i, pq[i].cmd, pq[i].addr, legal_list[i % 10], 32'h3000 + 32'(i));
            end
        end
    endtask

    task automatic test_reset_mid_fire();
        int k = 0;
        pq.delete();
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_cmd  = 4'd2;
            in_addr = 32'h4000 + 32'(i);
            tick();
        end
        in_valid = 1'b0;
        while (llc_eof !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        n_tests++; if (k >= 20) begin n_fail++; $display("FAIL midfire_wait: got no strobe expected strobe within 20 cycles"); end
        reset_n = 1'b0;
        tick();
        n_tests++; if (llc_eof !== 1'b0) begin n_fail++; $display("FAIL midfire_eof: got %b expected 0", llc_eof); end
        n_tests++; if (llc_cmd !== 4'd0) begin n_fail++; $display("FAIL midfire_cmd: got %h expected 0", llc_cmd); end
        n_tests++; if (llc_addr !== 32'd0) begin n_fail++; $display("FAIL midfire_addr: got %h expected 0", llc_addr); end
        n_tests++; if (issued_cnt !== 32'd0 || dropped_cnt !== 32'd0) begin n_fail++; $display("FAIL midfire_cnt: got %0d/%0d expected 0/0", issued_cnt, dropped_cnt); end
        n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL midfire_idle: got %b expected 1", idle); end
        reset_n = 1'b1;
        exp_issued  = 0;
        exp_dropped = 0;
        pq.delete();
        repeat (20) tick();
        n_tests++; if (pq.size() != 0) begin n_fail++; $display("FAIL midfire_abandon: got %0d pulses expected 0", pq.size()); end
        n_tests++; if (issued_cnt !== 32'd0) begin n_fail++; $display("FAIL midfire_issued: got %0d expected 0", issued_cnt); end
    endtask

    task automatic test_wrap();
        int acc = 0;
        int guard = 0;
        int both_err = 0;
        logic r;
        pq.delete();
        while ((acc < 24 || !(pq.size() >= 24 && idle === 1'b1)) && guard < 400) begin
            in_valid = (acc < 24);
            in_cmd   = legal_list[acc % 10];
            in_addr  = 32'(acc);
            r = in_ready;
            tick();
            if (r && acc < 24) acc++;
            if (in_ready !== 1'b1 && idle === 1'b1) both_err++;
            guard++;
        end
        in_valid = 1'b0;
        exp_issued += 24;
        n_tests++; if (guard >= 400) begin n_fail++; $display("FAIL wrap_timeout: got %0d pulses expected 24", pq.size()); end
        n_tests++; if (both_err != 0) begin n_fail++; $display("FAIL wrap_full_and_empty: got %0d cycles expected 0", both_err); end
        for (int i = 0; i < pq.size() && i < 24; i++) begin
            n_tests++;
            if (pq[i].cmd !== legal_list[i % 10] || pq[i].addr !== 32'(i)) begin
                n_fail++;
                $display("FAIL wrap_rec%0d: got %h/%h expected %h/%h", i, pq[i].cmd, pq[i].addr, legal_list[i % 10], 32'(i));
            end
        end
        n_tests++; if (issued_cnt !== 32'(exp_issued)) begin n_fail++; $display("FAIL wrap_issued: got %0d expected %0d", issued_cnt, exp_issued); end
        n_tests++; if (long_err != 0) begin n_fail++; $display("FAIL strobe_width: got %0d stretched expected 0", long_err); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_filter();
        test_simul_push_pop();
        test_reset_mid_fire();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
